// File: rtl/alu_issue.sv
// Decode-and-issue stage feeding the integer/FPU ALU: decodes one instruction,
// holds the operand bundle for the op latency, then hands the result to writeback.
// Optional feature: define ALU_ISSUE_FWD_EN to allow retire-and-accept in the same cycle.
module alu_issue #(
    parameter int INST_SIZE = 10,
    parameter int FPU_LAT   = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [31:0]          instr_in,
    input  logic [INST_SIZE-1:0] pc_in,
    input  logic [31:0]          rs_data,
    input  logic [31:0]          rt_data,
    output logic [1:0]           is_sorf,
    output logic [5:0]           op,
    output logic [31:0]          s,
    output logic [31:0]          t,
    output logic [31:0]          imm,
    output logic [4:0]           h,
    output logic [INST_SIZE-1:0] pc_out,
    output logic [4:0]           dst,
    output logic                 illegal,
    output logic                 res_valid,
    input  logic                 res_ready
);

    localparam logic [5:0] OP_SPECIAL = 6'b000000;
    localparam logic [5:0] OP_FPU     = 6'b010001;
    localparam logic [5:0] OP_J       = 6'b000010;
    localparam logic [5:0] OP_JAL     = 6'b000011;
    localparam logic [5:0] OP_BEQ     = 6'b000100;
    localparam logic [5:0] OP_BNE     = 6'b000101;
    localparam logic [5:0] OP_BLEZ    = 6'b000110;
    localparam logic [5:0] OP_BGTZ    = 6'b000111;
    localparam logic [5:0] OP_ADDI    = 6'b001000;
    localparam logic [5:0] OP_SLTI    = 6'b001010;
    localparam logic [5:0] OP_ANDI    = 6'b001100;
    localparam logic [5:0] OP_ORI     = 6'b001101;
    localparam logic [5:0] OP_XORI    = 6'b001110;
    localparam logic [5:0] OP_LUI     = 6'b001111;
    localparam logic [5:0] OP_LW      = 6'b100011;
    localparam logic [5:0] OP_SW      = 6'b101011;
    localparam logic [5:0] OP_OUT     = 6'b111111;

    typedef struct packed {
        logic [1:0]           sorf;
        logic [5:0]           op;
        logic [31:0]          s;
        logic [31:0]          t;
        logic [31:0]          imm;
        logic [4:0]           h;
        logic [INST_SIZE-1:0] pc;
        logic [4:0]           dst;
        logic                 ill;
    } issue_t;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t     state;
    logic [3:0] cnt;
    issue_t     bnd, dec;
    logic [3:0] dec_lat;
    logic [5:0] opc, fn;
    logic       accept;

    assign opc = instr_in[31:26];
    assign fn  = instr_in[5:0];

    always_comb begin
        dec      = '0;
        dec.s    = rs_data;
        dec.t    = rt_data;
        dec.h    = instr_in[10:6];
        dec.pc   = pc_in;
        dec_lat  = 4'd1;
        if (opc == OP_SPECIAL) begin
            dec.sorf = 2'b01;
            dec.op   = fn;
            dec.dst  = instr_in[15:11];
        end else if (opc == OP_FPU) begin
            dec.sorf = 2'b10;
            dec.op   = fn;
            dec.dst  = instr_in[15:11];
            // ADD/SUB/MUL/SQRT run in the multi-cycle FPU datapath
            if (fn == 6'b000000 || fn == 6'b000001 || fn == 6'b000010 || fn == 6'b000100)
                dec_lat = 4'(FPU_LAT);
        end else begin
            dec.sorf = 2'b00;
            dec.op   = opc;
            dec.dst  = instr_in[20:16];
        end
        case (opc)
            OP_ADDI, OP_SLTI, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_BGTZ, OP_BLEZ:
                dec.imm = {{16{instr_in[15]}}, instr_in[15:0]};
            OP_ANDI, OP_ORI, OP_XORI:
                dec.imm = {16'h0, instr_in[15:0]};
            OP_LUI:
                dec.imm = {instr_in[15:0], 16'h0};
            OP_J, OP_JAL:
                dec.imm = {6'h0, instr_in[25:0]};
            default:
                dec.imm = 32'h0;
        endcase
        case (opc)
            OP_SPECIAL, OP_FPU, OP_LW, OP_SW, OP_ADDI, OP_ANDI, OP_ORI, OP_XORI,
            OP_SLTI, OP_LUI, OP_BEQ, OP_BNE, OP_BGTZ, OP_BLEZ, OP_J, OP_JAL, OP_OUT:
                dec.ill = 1'b0;
            default:
                dec.ill = 1'b1;
        endcase
    end

`ifdef ALU_ISSUE_FWD_EN
    assign in_ready = (state == IDLE) || (state == DONE && res_ready);
`else
    assign in_ready = (state == IDLE);
`endif

    assign accept    = in_valid && in_ready;
    assign res_valid = (state == DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= 4'd0;
            bnd   <= '0;
        end else if (accept) begin
            // accept is only possible in IDLE, or in DONE while retiring
            bnd   <= dec;
            cnt   <= dec_lat - 4'd1;
            state <= BUSY;
        end else begin
            case (state)
                BUSY: begin
                    if (cnt == 4'd0) state <= DONE;
                    else             cnt   <= cnt - 4'd1;
                end
                DONE: if (res_ready) state <= IDLE;
                default: ;
            endcase
        end
    end

    assign is_sorf = bnd.sorf;
    assign op      = bnd.op;
    assign s       = bnd.s;
    assign t       = bnd.t;
    assign imm     = bnd.imm;
    assign h       = bnd.h;
    assign pc_out  = bnd.pc;
    assign dst     = bnd.dst;
    assign illegal = bnd.ill;

endmodule

// File: tb/tb_alu_issue.sv
// Self-checking bench for alu_issue: directed literal cases plus randomized traffic
// checked every cycle against a cycle-count model of issue/retire.
module tb_alu_issue;

    localparam int INST_SIZE = 10;
    localparam int FPU_LAT   = 3;
`ifdef ALU_ISSUE_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 in_valid = 1'b0;
    logic                 in_ready;
    logic [31:0]          instr_in = '0;
    logic [INST_SIZE-1:0] pc_in = '0;
    logic [31:0]          rs_data = '0, rt_data = '0;
    logic [1:0]           is_sorf;
    logic [5:0]           op;
    logic [31:0]          s, t, imm;
    logic [4:0]           h, dst;
    logic [INST_SIZE-1:0] pc_out;
    logic                 illegal, res_valid;
    logic                 res_ready = 1'b1;

    alu_issue #(.INST_SIZE(INST_SIZE), .FPU_LAT(FPU_LAT)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .instr_in(instr_in), .pc_in(pc_in), .rs_data(rs_data), .rt_data(rt_data),
        .is_sorf(is_sorf), .op(op), .s(s), .t(t), .imm(imm), .h(h),
        .pc_out(pc_out), .dst(dst), .illegal(illegal),
        .res_valid(res_valid), .res_ready(res_ready)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_fail = 0, cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    typedef struct {
        logic [1:0]  sorf;
        logic [5:0]  op;
        logic [31:0] s, t, imm;
        logic [4:0]  h, dst;
        logic [31:0] pc;
        logic        ill;
        int          lat;
    } bund_t;

    // Reference decode written from the opcode tables directly
    function automatic bund_t model_dec(input logic [31:0] ins, input logic [31:0] rs,
                                        input logic [31:0] rt, input logic [31:0] pc);
        bund_t b;
        int opc, fn;
        int sext_ops[8] = '{8, 10, 35, 43, 4, 5, 7, 6};
        int zext_ops[3] = '{12, 13, 14};
        int legal[17]   = '{0, 17, 35, 43, 8, 12, 13, 14, 10, 15, 4, 5, 7, 6, 2, 3, 63};
        opc = int'(ins[31:26]);
        fn  = int'(ins[5:0]);
        b.s = rs; b.t = rt; b.h = ins[10:6]; b.pc = pc; b.lat = 1; b.imm = 0;
        if (opc == 0)       begin b.sorf = 2'd1; b.op = 6'(fn);  b.dst = ins[15:11]; end
        else if (opc == 17) begin b.sorf = 2'd2; b.op = 6'(fn);  b.dst = ins[15:11]; end
        else                begin b.sorf = 2'd0; b.op = 6'(opc); b.dst = ins[20:16]; end
        if (opc == 17 && (fn == 0 || fn == 1 || fn == 2 || fn == 4)) b.lat = FPU_LAT;
        foreach (sext_ops[i]) if (opc == sext_ops[i]) b.imm = 32'($signed(ins[15:0]));
        foreach (zext_ops[i]) if (opc == zext_ops[i]) b.imm = 32'(ins[15:0]);
        if (opc == 15) b.imm = 32'(ins[15:0]) * 65536;
        if (opc == 2 || opc == 3) b.imm = 32'(ins[25:0]);
        b.ill = 1'b1;
        foreach (legal[i]) if (opc == legal[i]) b.ill = 1'b0;
        return b;
    endfunction

    // Model: an issued instruction becomes valid L+1 cycles after acceptance
    bund_t m_b = '{default: 0};
    bit    m_busy = 0;
    int    m_ready_at = 0;
    bit    exp_rv, exp_ir;

    always @(negedge clk) begin
        if (rst) begin
            m_busy = 0;
            m_b    = '{default: 0};
        end
        exp_rv = m_busy && (cyc >= m_ready_at);
        exp_ir = !m_busy || (FWD && exp_rv && res_ready);
        chk("res_valid", 32'(res_valid), 32'(exp_rv));
        chk("in_ready",  32'(in_ready),  32'(exp_ir));
        chk("is_sorf",   32'(is_sorf),   32'(m_b.sorf));
        chk("op",        32'(op),        32'(m_b.op));
        chk("s",         s,              m_b.s);
        chk("t",         t,              m_b.t);
        chk("imm",       imm,            m_b.imm);
        chk("h",         32'(h),         32'(m_b.h));
        chk("pc_out",    32'(pc_out),    m_b.pc);
        chk("dst",       32'(dst),       32'(m_b.dst));
        chk("illegal",   32'(illegal),   32'(m_b.ill));
        if (!rst) begin
            if (in_valid && exp_ir) begin
                m_b        = model_dec(instr_in, rs_data, rt_data, 32'(pc_in));
                m_busy     = 1;
                m_ready_at = cyc + m_b.lat + 1;
            end else if (exp_rv && res_ready) begin
                m_busy = 0;
            end
        end
    end

    // Present one instruction until accepted; returns at posedge+1 after the transfer edge
    task automatic send(input logic [31:0] ins, input logic [31:0] rs, input logic [31:0] rt);
        bit done = 0;
        instr_in = ins; rs_data = rs; rt_data = rt; pc_in = INST_SIZE'($urandom);
        in_valid = 1'b1;
        for (int k = 0; k < 50 && !done; k++) begin
            @(negedge clk);
            if (in_ready) done = 1;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        if (!done) begin n_chk++; n_fail++; $display("FAIL send: in_ready never rose"); end
    endtask

    // Cycles from the accepting edge until res_valid is seen (0 on timeout)
    task automatic lat_to_valid(output int lat, input bit want_busy_ir0);
        lat = 0;
        for (int k = 1; k < 40; k++) begin
            @(negedge clk);
            if (res_valid) begin lat = k; break; end
            if (want_busy_ir0) chk("busy in_ready", 32'(in_ready), 32'd0);
        end
    endtask

    logic [31:0] rand_instr_r;
    function automatic logic [31:0] rand_instr();
        logic [31:0] r;
        logic [5:0]  legal[15] = '{6'd35, 6'd43, 6'd8, 6'd12, 6'd13, 6'd14, 6'd10, 6'd15,
                                   6'd4, 6'd5, 6'd7, 6'd6, 6'd2, 6'd3, 6'd63};
        logic [5:0]  ffn[5] = '{6'd0, 6'd1, 6'd2, 6'd4, 6'd9};
        int          sel;
        r   = $urandom;
        sel = $urandom_range(0, 9);
        if (sel < 2)       r[31:26] = 6'd0;
        else if (sel < 4) begin r[31:26] = 6'd17; r[5:0] = ffn[$urandom_range(0, 4)]; end
        else if (sel == 4) r[31:26] = 6'($urandom);
        else               r[31:26] = legal[$urandom_range(0, 14)];
        return r;
    endfunction

    int lat, acc[$];

    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk("reset in_ready", 32'(in_ready), 32'd1);
        chk("reset res_valid", 32'(res_valid), 32'd0);

        // ADDI $2,$1,-4
        send(32'h2022FFFC, 32'd10, 32'd0);
        @(negedge clk);
        chk("addi sorf", 32'(is_sorf), 32'd0);
        chk("addi op", 32'(op), 32'h08);
        chk("addi imm", imm, 32'hFFFFFFFC);
        chk("addi dst", 32'(dst), 32'd2);
        chk("addi s", s, 32'd10);
        lat_to_valid(lat, 1'b1);
        chk("addi latency", 32'(lat + 1), 32'd2);
        @(posedge clk); #1;

        // R-type ADD with a 5-cycle writeback stall
        res_ready = 1'b0;
        send(32'h00221820, 32'd7, 32'd9);
        lat_to_valid(lat, 1'b1);
        chk("radd latency", 32'(lat), 32'd2);
        for (int k = 0; k < 5; k++) begin
            chk("stall res_valid", 32'(res_valid), 32'd1);
            chk("stall sorf", 32'(is_sorf), 32'd1);
            chk("stall op", 32'(op), 32'h20);
            chk("stall dst", 32'(dst), 32'd3);
            @(negedge clk);
        end
        @(posedge clk); #1 res_ready = 1'b1;
        @(posedge clk); #1;

        // FPU MUL
        send(32'h44221882, 32'd1, 32'd2);
        lat_to_valid(lat, 1'b1);
        chk("fmul latency", 32'(lat), 32'(FPU_LAT + 1));
        chk("fmul sorf", 32'(is_sorf), 32'd2);
        @(posedge clk); #1;

        send(32'h34228000, 32'd0, 32'd0);
        @(negedge clk);
        chk("ori imm", imm, 32'h00008000);
        @(posedge clk); #1; @(posedge clk); #1;
        send(32'h3C021234, 32'd0, 32'd0);
        @(negedge clk);
        chk("lui imm", imm, 32'h12340000);
        @(posedge clk); #1; @(posedge clk); #1;

        // Illegal opcode 0x3A still issues with latency 1
        send(32'hE8000000, 32'd0, 32'd0);
        lat_to_valid(lat, 1'b0);
        chk("illegal latency", 32'(lat), 32'd2);
        chk("illegal flag", 32'(illegal), 32'd1);
        @(posedge clk); #1;

        // Reset during BUSY of an FPU ADD
        send(32'h44221880, 32'd3, 32'd4);
        #2 rst = 1'b1;
        @(negedge clk);
        chk("rst in_ready", 32'(in_ready), 32'd1);
        chk("rst res_valid", 32'(res_valid), 32'd0);
        chk("rst sorf", 32'(is_sorf), 32'd0);
        chk("rst s", s, 32'd0);
        @(posedge clk); #1 rst = 1'b0;

        // Back-to-back single-cycle ops
        instr_in = 32'h00221820; res_ready = 1'b1; in_valid = 1'b1;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (in_ready) acc.push_back(cyc);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        if (acc.size() >= 3) chk("b2b interval", 32'(acc[2] - acc[1]), FWD ? 32'd2 : 32'd3);
        else begin n_chk++; n_fail++; $display("FAIL b2b: only %0d accepts", acc.size()); end
        @(posedge clk); #1;

        for (int i = 0; i < 1500; i++) begin
            rst       = ($urandom_range(0, 299) == 0);
            in_valid  = $urandom_range(0, 1);
            res_ready = ($urandom_range(0, 9) < 7);
            rand_instr_r = rand_instr();
            instr_in  = rand_instr_r;
            rs_data   = $urandom;
            rt_data   = $urandom;
            pc_in     = INST_SIZE'($urandom);
            @(posedge clk); #1;
        end
        rst = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
